// File: rtl/dir_controller.sv
// Full-map directory coherence controller: tracks I/S/M plus a sharer vector per line,
// issues invalidate/fetch requests to L1 caches and grants the requested permission.
module dir_controller #(
  parameter int NUM_CACHES = 2,
  parameter int ADDR_WIDTH = 8,
  localparam int SRC_W = (NUM_CACHES > 2) ? $clog2(NUM_CACHES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SRC_W-1:0]      req_src,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_CACHES-1:0] inv_valid,
  output logic                  inv_fetch,
  output logic [ADDR_WIDTH-1:0] inv_addr,
  input  logic [NUM_CACHES-1:0] inv_ack,
  output logic                  grant_valid,
  output logic [SRC_W-1:0]      grant_dst,
  output logic [1:0]            grant_state,
  output logic [ADDR_WIDTH-1:0] grant_addr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] OP_GETS = 2'b00;
  localparam logic [1:0] OP_GETM = 2'b01;
  localparam logic [1:0] OP_PUTM = 2'b10;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  typedef enum logic [1:0] {IDLE, LOOKUP, INVAL, GRANT} fsm_t;

  fsm_t                  fsm_reg;
  logic [SRC_W-1:0]      src_reg;
  logic [1:0]            op_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [1:0]            new_state_reg;
  logic [NUM_CACHES-1:0] new_sharers_reg;
  logic [1:0]            grant_kind_reg;
  logic [NUM_CACHES-1:0] pending_reg;
  logic                  fetch_reg;
  logic [ADDR_WIDTH-1:0] inv_addr_reg;
  logic                  ready_reg;
  logic                  gvalid_reg;
  logic [SRC_W-1:0]      gdst_reg;
  logic [1:0]            gstate_reg;
  logic [ADDR_WIDTH-1:0] gaddr_reg;

  logic [1:0]            dir_state   [DEPTH];
  logic [NUM_CACHES-1:0] dir_sharers [DEPTH];

  logic [1:0]            cur_state;
  logic [NUM_CACHES-1:0] cur_sharers;
  logic [NUM_CACHES-1:0] src_mask;
  logic                  owner_is_src;
  logic [1:0]            lk_state;
  logic [NUM_CACHES-1:0] lk_sharers;
  logic [1:0]            lk_grant;
  logic [NUM_CACHES-1:0] lk_target;
  logic                  lk_fetch;
  logic [NUM_CACHES-1:0] pending_next;
  logic                  dir_we;

  assign cur_state    = dir_state[addr_reg];
  assign cur_sharers  = dir_sharers[addr_reg];
  assign src_mask     = NUM_CACHES'(1) << src_reg;
  assign owner_is_src = |(cur_sharers & src_mask);
  assign pending_next = pending_reg & ~inv_ack;
  assign dir_we       = (fsm_reg == GRANT);

  // Next entry contents, caches to invalidate/fetch, and permission to grant.
  always_comb begin
    lk_state   = cur_state;
    lk_sharers = cur_sharers;
    lk_grant   = ST_I;
    lk_target  = '0;
    lk_fetch   = 1'b0;
    case (op_reg)
      OP_GETS: begin
        if (cur_state == ST_M && owner_is_src) begin
          lk_grant = ST_M;
        end else begin
          lk_state   = ST_S;
          lk_sharers = cur_sharers | src_mask;
          lk_grant   = ST_S;
          if (cur_state == ST_M) begin
            lk_target = cur_sharers;
            lk_fetch  = 1'b1;
          end
        end
      end
      OP_GETM: begin
        lk_grant = ST_M;
        if (!(cur_state == ST_M && owner_is_src)) begin
          lk_state   = ST_M;
          lk_sharers = src_mask;
          lk_target  = cur_sharers & ~src_mask;
          lk_fetch   = (cur_state == ST_M);
        end
      end
      OP_PUTM: begin
        if (cur_state == ST_M && owner_is_src) begin
          lk_state   = ST_I;
          lk_sharers = '0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        dir_state[i]   <= ST_I;
        dir_sharers[i] <= '0;
      end
    end else if (dir_we) begin
      dir_state[addr_reg]   <= new_state_reg;
      dir_sharers[addr_reg] <= new_sharers_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_reg         <= IDLE;
      src_reg         <= '0;
      op_reg          <= '0;
      addr_reg        <= '0;
      new_state_reg   <= ST_I;
      new_sharers_reg <= '0;
      grant_kind_reg  <= ST_I;
      pending_reg     <= '0;
      fetch_reg       <= 1'b0;
      inv_addr_reg    <= '0;
      ready_reg       <= 1'b0;
      gvalid_reg      <= 1'b0;
      gdst_reg        <= '0;
      gstate_reg      <= '0;
      gaddr_reg       <= '0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          ready_reg <= 1'b1;
          if (req_valid && ready_reg) begin
            src_reg   <= req_src;
            op_reg    <= req_op;
            addr_reg  <= req_addr;
            ready_reg <= 1'b0;
            fsm_reg   <= LOOKUP;
          end
        end
        LOOKUP: begin
          new_state_reg   <= lk_state;
          new_sharers_reg <= lk_sharers;
          grant_kind_reg  <= lk_grant;
          if (|lk_target) begin
            pending_reg  <= lk_target;
            fetch_reg    <= lk_fetch;
            inv_addr_reg <= addr_reg;
            fsm_reg      <= INVAL;
          end else begin
            gvalid_reg <= 1'b1;
            gdst_reg   <= src_reg;
            gstate_reg <= lk_grant;
            gaddr_reg  <= addr_reg;
            fsm_reg    <= GRANT;
          end
        end
        INVAL: begin
          // Acks on bits that are not pending fall out of the mask naturally.
          pending_reg <= pending_next;
          if (pending_next == '0) begin
            fetch_reg    <= 1'b0;
            inv_addr_reg <= '0;
            gvalid_reg   <= 1'b1;
            gdst_reg     <= src_reg;
            gstate_reg   <= grant_kind_reg;
            gaddr_reg    <= addr_reg;
            fsm_reg      <= GRANT;
          end
        end
        GRANT: begin
          gvalid_reg <= 1'b0;
          gdst_reg   <= '0;
          gstate_reg <= '0;
          gaddr_reg  <= '0;
          ready_reg  <= 1'b1;
          fsm_reg    <= IDLE;
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

  assign req_ready   = ready_reg;
  assign inv_valid   = pending_reg;
  assign inv_fetch   = fetch_reg;
  assign inv_addr    = inv_addr_reg;
  assign grant_valid = gvalid_reg;
  assign grant_dst   = gdst_reg;
  assign grant_state = gstate_reg;
  assign grant_addr  = gaddr_reg;

endmodule

// File: tb/tb_dir_controller.sv
// Self-checking bench for dir_controller (4 caches, 8-bit addresses): grants are
// checked against a scoreboard queue, invalidation traffic and latency inline.
module tb_dir_controller;

  localparam logic [1:0] OP_GETS = 2'b00;
  localparam logic [1:0] OP_GETM = 2'b01;
  localparam logic [1:0] OP_PUTM = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;
  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_src = '0;
  logic [1:0] req_op = '0;
  logic [7:0] req_addr = '0;
  logic [3:0] inv_valid;
  logic       inv_fetch;
  logic [7:0] inv_addr;
  logic [3:0] inv_ack = '0;
  logic       grant_valid;
  logic [1:0] grant_dst;
  logic [1:0] grant_state;
  logic [7:0] grant_addr;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [1:0] dst;
    logic [1:0] st;
    logic [7:0] addr;
  } exp_t;
  exp_t sb[$];

  dir_controller #(.NUM_CACHES(4), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_src(req_src),
    .req_op(req_op), .req_addr(req_addr),
    .inv_valid(inv_valid), .inv_fetch(inv_fetch), .inv_addr(inv_addr), .inv_ack(inv_ack),
    .grant_valid(grant_valid), .grant_dst(grant_dst), .grant_state(grant_state),
    .grant_addr(grant_addr)
  );

  always #5 clk = ~clk;

  // Scoreboard: every grant pops the oldest expected completion.
  always @(negedge clk) begin
    if (!reset && grant_valid === 1'b1) begin
      exp_t e;
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL grant_unexpected: dst=%0d state=%b addr=%h, required no grant",
                 grant_dst, grant_state, grant_addr);
      end else begin
        e = sb.pop_front();
        if ({grant_dst, grant_state, grant_addr} !== {e.dst, e.st, e.addr}) begin
          tests_failed++;
          $display("FAIL grant_fields: dst=%0d state=%b addr=%h, required dst=%0d state=%b addr=%h",
                   grant_dst, grant_state, grant_addr, e.dst, e.st, e.addr);
        end else begin
          $display("[TB] grant dst=%0d state=%b addr=%h", grant_dst, grant_state, grant_addr);
        end
      end
    end
  end

  // Issues one request, pulses acks at the given cycle offsets (0 = never) and
  // reports what was observed; k=1 is the cycle after the handshake edge.
  task automatic drive_txn(input logic [1:0] src, input logic [1:0] op, input logic [7:0] addr,
                           input logic [1:0] exp_state, input logic [3:0][7:0] ack_k,
                           output int lat, output logic [3:0] inv_first, output logic [3:0] inv_k3,
                           output logic fetch_seen, output logic [7:0] iaddr_seen,
                           output logic ready_after, output logic lookup_quiet);
    int  n;
    bit  done;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL ready_wait: req_ready=%b, required 1 within 50 cycles", req_ready);
    end
    req_valid = 1'b1;
    req_src   = src;
    req_op    = op;
    req_addr  = addr;
    sb.push_back('{dst: src, st: exp_state, addr: addr});
    @(negedge clk);
    req_valid = 1'b0;
    req_src   = '0;
    req_op    = '0;
    req_addr  = '0;
    lat = 0; inv_first = '0; inv_k3 = '0; fetch_seen = 1'b0; iaddr_seen = '0;
    ready_after = 1'b0; lookup_quiet = 1'b0;
    done = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      if (k == 1)
        lookup_quiet = (inv_valid === 4'b0 && inv_fetch === 1'b0 && inv_addr === 8'h00 &&
                        grant_valid === 1'b0);
      if (inv_first == 4'b0 && inv_valid !== 4'b0) begin
        inv_first  = inv_valid;
        fetch_seen = inv_fetch;
        iaddr_seen = inv_addr;
      end
      if (k == 3) inv_k3 = inv_valid;
      if (grant_valid === 1'b1) begin
        lat  = k;
        done = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) inv_ack[i] = (ack_k[i] == 8'(k));
        @(negedge clk);
      end
    end
    inv_ack = '0;
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL grant_timeout: no grant for src=%0d op=%b addr=%h", src, op, addr);
    end
    @(negedge clk);
    ready_after = req_ready;
    $display("[TB] txn src=%0d op=%b addr=%h lat=%0d inv=%b fetch=%b", src, op, addr, lat,
             inv_first, fetch_seen);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({req_ready, inv_valid, inv_fetch, inv_addr, grant_valid, grant_dst, grant_state,
         grant_addr} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ready=%b inv=%b fetch=%b grant=%b, required all 0",
               req_ready, inv_valid, inv_fetch, grant_valid);
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready_rise: req_ready=%b, required 1", req_ready);
    end
  endtask

  task automatic test_gets_basic();
    int lat; logic [3:0] i1, i3; logic f, rdy, q; logic [7:0] ia;
    drive_txn(2'd0, OP_GETS, 8'h10, ST_S, '0, lat, i1, i3, f, ia, rdy, q);
    tests_run++;
    if (lat !== 2) begin tests_failed++; $display("FAIL gets_latency: got %0d, required 2", lat); end
    tests_run++;
    if (i1 !== 4'b0000) begin tests_failed++; $display("FAIL gets_no_inval: inv=%b, required 0000", i1); end
    tests_run++;
    if (rdy !== 1'b1) begin tests_failed++; $display("FAIL gets_ready_t3: req_ready=%b, required 1", rdy); end
    tests_run++;
    if (q !== 1'b1) begin tests_failed++; $display("FAIL lookup_quiet: outputs nonzero in lookup, required zero"); end
  endtask

  task automatic test_getm_inval();
    int lat; logic [3:0] i1, i3; logic f, rdy, q; logic [7:0] ia;
    drive_txn(2'd1, OP_GETS, 8'h10, ST_S, '0, lat, i1, i3, f, ia, rdy, q);
    drive_txn(2'd2, OP_GETS, 8'h10, ST_S, '0, lat, i1, i3, f, ia, rdy, q);
    tests_run++;
    if (i1 !== 4'b0000) begin tests_failed++; $display("FAIL gets_share_no_inval: inv=%b, required 0000", i1); end
    // Cache 0 acks in INVAL cycle 1, cache 2 in cycle 2, cache 1 in cycle 3; cache 3 is not pending.
    drive_txn(2'd3, OP_GETM, 8'h10, ST_M, {8'd2, 8'd3, 8'd4, 8'd2}, lat, i1, i3, f, ia, rdy, q);
    tests_run++;
    if (i1 !== 4'b0111) begin tests_failed++; $display("FAIL getm_inv_mask: inv=%b, required 0111", i1); end
    tests_run++;
    if (f !== 1'b0) begin tests_failed++; $display("FAIL getm_inv_fetch: fetch=%b, required 0", f); end
    tests_run++;
    if (ia !== 8'h10) begin tests_failed++; $display("FAIL getm_inv_addr: addr=%h, required 10", ia); end
    tests_run++;
    if (i3 !== 4'b0110) begin tests_failed++; $display("FAIL getm_ack_clear: inv=%b, required 0110", i3); end
    tests_run++;
    if (lat !== 5) begin tests_failed++; $display("FAIL getm_inval_latency: got %0d, required 5", lat); end
    drive_txn(2'd0, OP_GETS, 8'h10, ST_S, {8'd2, 8'd0, 8'd0, 8'd0}, lat, i1, i3, f, ia, rdy, q);
    tests_run++;
    if ({i1, f} !== {4'b1000, 1'b1}) begin
      tests_failed++; $display("FAIL getm_owner_is_3: inv=%b fetch=%b, required 1000/1", i1, f);
    end
    tests_run++;
    if (lat !== 3) begin tests_failed++; $display("FAIL fetch_latency: got %0d, required 3", lat); end
  endtask

  task automatic test_gets_from_m();
    int lat; logic [3:0] i1, i3; logic f, rdy, q; logic [7:0] ia;
    drive_txn(2'd2, OP_GETM, 8'h20, ST_M, '0, lat, i1, i3, f, ia, rdy, q);
    tests_run++;
    if (lat !== 2) begin tests_failed++; $display("FAIL getm_from_i_latency: got %0d, required 2", lat); end
    drive_txn(2'd0, OP_GETS, 8'h20, ST_S, {8'd0, 8'd3, 8'd0, 8'd0}, lat, i1, i3, f, ia, rdy, q);
    tests_run++;
    if ({i1, f, ia} !== {4'b0100, 1'b1, 8'h20}) begin
      tests_failed++; $display("FAIL gets_m_fetch: inv=%b fetch=%b addr=%h, required 0100/1/20", i1, f, ia);
    end
    tests_run++;
    if (lat !== 4) begin tests_failed++; $display("FAIL gets_m_latency: got %0d, required 4", lat); end
    // Both sharers ack in the same cycle.
    drive_txn(2'd1, OP_GETM, 8'h20, ST_M, {8'd0, 8'd2, 8'd0, 8'd2}, lat, i1, i3, f, ia, rdy, q);
    tests_run++;
    if ({i1, f} !== {4'b0101, 1'b0}) begin
      tests_failed++; $display("FAIL sharers_0101: inv=%b fetch=%b, required 0101/0", i1, f);
    end
    tests_run++;
    if (lat !== 3) begin tests_failed++; $display("FAIL simul_ack_latency: got %0d, required 3", lat); end
  endtask

  task automatic test_putm();
    int lat; logic [3:0] i1, i3; logic f, rdy, q; logic [7:0] ia;
    drive_txn(2'd2, OP_GETM, 8'h30, ST_M, '0, lat, i1, i3, f, ia, rdy, q);
    drive_txn(2'd1, OP_PUTM, 8'h30, ST_I, '0, lat, i1, i3, f, ia, rdy, q);
    tests_run++;
    if ({lat, i1} !== {32'd2, 4'b0000}) begin
      tests_failed++; $display("FAIL stale_putm: lat=%0d inv=%b, required 2/0000", lat, i1);
    end
    drive_txn(2'd2, OP_GETS, 8'h30, ST_M, '0, lat, i1, i3, f, ia, rdy, q);
    drive_txn(2'd2, OP_PUTM, 8'h30, ST_I, '0, lat, i1, i3, f, ia, rdy, q);
    drive_txn(2'd1, OP_GETS, 8'h30, ST_S, '0, lat, i1, i3, f, ia, rdy, q);
    tests_run++;
    if (i1 !== 4'b0000) begin tests_failed++; $display("FAIL putm_cleared: inv=%b, required 0000", i1); end
  endtask

  task automatic test_upgrade();
    int lat; logic [3:0] i1, i3; logic f, rdy, q; logic [7:0] ia;
    drive_txn(2'd0, OP_GETS, 8'h40, ST_S, '0, lat, i1, i3, f, ia, rdy, q);
    drive_txn(2'd0, OP_GETM, 8'h40, ST_M, '0, lat, i1, i3, f, ia, rdy, q);
    tests_run++;
    if ({lat, i1} !== {32'd2, 4'b0000}) begin
      tests_failed++; $display("FAIL upgrade: lat=%0d inv=%b, required 2/0000", lat, i1);
    end
    drive_txn(2'd1, OP_RSVD, 8'h40, ST_I, '0, lat, i1, i3, f, ia, rdy, q);
    tests_run++;
    if (lat !== 2) begin tests_failed++; $display("FAIL reserved_latency: got %0d, required 2", lat); end
    drive_txn(2'd0, OP_GETS, 8'h40, ST_M, '0, lat, i1, i3, f, ia, rdy, q);
  endtask

  task automatic test_back_to_back();
    int lat; logic [3:0] i1, i3; logic f, rdy, q; logic [7:0] ia;
    drive_txn(2'd1, OP_GETM, 8'h50, ST_M, '0, lat, i1, i3, f, ia, rdy, q);
    drive_txn(2'd1, OP_GETS, 8'h50, ST_M, '0, lat, i1, i3, f, ia, rdy, q);
    drive_txn(2'd3, OP_GETS, 8'h50, ST_S, {8'd0, 8'd0, 8'd2, 8'd0}, lat, i1, i3, f, ia, rdy, q);
    tests_run++;
    if ({i1, f, lat} !== {4'b0010, 1'b1, 32'd3}) begin
      tests_failed++; $display("FAIL b2b_fetch: inv=%b fetch=%b lat=%0d, required 0010/1/3", i1, f, lat);
    end
  endtask

  task automatic test_reset_mid_inval();
    int lat; logic [3:0] i1, i3; logic f, rdy, q; logic [7:0] ia;
    drive_txn(2'd1, OP_GETS, 8'h60, ST_S, '0, lat, i1, i3, f, ia, rdy, q);
    drive_txn(2'd2, OP_GETS, 8'h60, ST_S, '0, lat, i1, i3, f, ia, rdy, q);
    req_valid = 1'b1; req_src = 2'd0; req_op = OP_GETM; req_addr = 8'h60;
    @(negedge clk);
    req_valid = 1'b0; req_op = '0; req_addr = '0;
    @(negedge clk);
    tests_run++;
    if (inv_valid !== 4'b0110) begin tests_failed++; $display("FAIL abort_inv_mask: inv=%b, required 0110", inv_valid); end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({req_ready, inv_valid, inv_fetch, inv_addr, grant_valid, grant_dst, grant_state,
         grant_addr} !== '0) begin
      tests_failed++;
      $display("FAIL abort_outputs: ready=%b inv=%b grant=%b, required all 0", req_ready, inv_valid, grant_valid);
    end
    reset = 1'b0;
    inv_ack = 4'b0110;
    @(negedge clk);
    inv_ack = '0;
    tests_run++;
    if ({inv_valid, grant_valid, req_ready} !== {4'b0000, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL late_ack: inv=%b grant=%b ready=%b, required 0000/0/1", inv_valid, grant_valid, req_ready);
    end
    repeat (3) @(negedge clk);
    drive_txn(2'd0, OP_GETM, 8'h60, ST_M, '0, lat, i1, i3, f, ia, rdy, q);
    tests_run++;
    if ({lat, i1} !== {32'd2, 4'b0000}) begin
      tests_failed++; $display("FAIL abort_entry_i: lat=%0d inv=%b, required 2/0000", lat, i1);
    end
    drive_txn(2'd3, OP_GETM, 8'h10, ST_M, '0, lat, i1, i3, f, ia, rdy, q);
    tests_run++;
    if (i1 !== 4'b0000) begin tests_failed++; $display("FAIL dir_cleared: inv=%b, required 0000", i1); end
  endtask

  initial begin
    test_reset();
    test_gets_basic();
    test_getm_inval();
    test_gets_from_m();
    test_putm();
    test_upgrade();
    test_back_to_back();
    test_reset_mid_inval();
    repeat (2) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d grants outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
